// File: rtl/rpg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rpg_pkg
// Description : Shared types, constants and helpers for random_pulse_gen_mc.
//               Holds the per-channel state enum, default LFSR taps and seed,
//               and the chan_byte() rotate that derives each channel's random
//               byte from the shared LFSR.
// Revision    : 1.0 - initial release
// ============================================================================
package rpg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        HOLD = 2'd2
    } rpg_state_e;

    // x^16 + x^14 + x^13 + x^11 + 1 in Galois (right-shift) form
    localparam logic [15:0] C_DEF_TAPS = 16'hB400;
    localparam logic [15:0] C_DEF_SEED = 16'hACE1;

    // Low 8 bits of an lfsr_w-bit word rotated left by 3*idx (mod lfsr_w).
    // The LFSR is passed zero-extended to 64 bits so one function serves any
    // width from 8 to 64. Rotating gives each channel a different view of the
    // same state, so channels trigger largely independently.
    function automatic logic [7:0] chan_byte(input logic [63:0] lfsr,
                                             input int          lfsr_w,
                                             input int          idx);
        int         sh;
        int         src;
        logic [7:0] b;
        b  = '0;
        sh = (3 * idx) % lfsr_w;
        for (int k = 0; k < 8; k++) begin
            // rotate-left: output bit k comes from input bit (k - sh) mod W
            src          = (k - sh + lfsr_w) % lfsr_w;
            b[3'(k)]     = lfsr[6'(src)];
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rpg_channel.sv
`default_nettype none
// ============================================================================
// Module      : rpg_channel
// Description : One pulse channel. Triggers from IDLE when its random byte is
//               below the density threshold (or density is 8'hFF), then emits
//               a pulse of the latched width followed by the latched hold-off.
//               Optional saturating pulse-start counter when PULSE_COUNT_EN is
//               defined; otherwise count is tied to zero.
// Ports       : clk, rst_n (async, active-low), en, rnd[7:0], density[7:0],
//               width[PW_W-1:0], gap[PW_W-1:0] -> pulse, busy, count[15:0]
// Revision    : 1.0 - initial release
// ============================================================================
module rpg_channel
    import rpg_pkg::*;
#(
    parameter int PW_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [7:0]      rnd,
    input  logic [7:0]      density,
    input  logic [PW_W-1:0] width,
    input  logic [PW_W-1:0] gap,
    output logic            pulse,
    output logic            busy,
    output logic [15:0]     count
);

    localparam logic [PW_W-1:0] c_one = PW_W'(1);

    rpg_state_e      r_state;
    rpg_state_e      w_state_nxt;
    logic [PW_W-1:0] r_cnt;        // cycles remaining in the current phase, minus one
    logic [PW_W-1:0] w_cnt_nxt;
    logic [PW_W-1:0] r_gap;        // gap latched at trigger time
    logic [PW_W-1:0] w_gap_nxt;
    logic            r_pulse;
    logic            w_trig;

    assign w_trig = en && (r_state == IDLE) &&
                    ((density == 8'hFF) || (rnd < density));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_gap   <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gap   <= w_gap_nxt;
            r_pulse <= (w_state_nxt == HIGH);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_gap_nxt   = r_gap;
        case (r_state)
            IDLE: begin
                if (w_trig) begin
                    w_state_nxt = HIGH;
                    // width 0 behaves as 1, i.e. zero extra cycles
                    w_cnt_nxt   = (width == '0) ? '0 : width - c_one;
                    w_gap_nxt   = gap;
                end
            end
            HIGH: begin
                if (r_cnt == '0) begin
                    if (r_gap != '0) begin
                        w_state_nxt = HOLD;
                        w_cnt_nxt   = r_gap - c_one;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - c_one;
                end
            end
            HOLD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - c_one;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign pulse = r_pulse;
    assign busy  = (r_state != IDLE);

`ifdef PULSE_COUNT_EN
    logic [15:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_trig && (r_count != 16'hFFFF)) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign count = r_count;
`else
    assign count = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: rtl/random_pulse_gen_mc.sv
`default_nettype none
// ============================================================================
// Module      : random_pulse_gen_mc
// Description : Multi-channel random pulse generator. A shared Galois LFSR
//               feeds N_CH rpg_channel instances, each seeing its own rotated
//               byte of the LFSR. Optional per-channel pulse-start counters
//               (macro PULSE_COUNT_EN) are read back through cnt_sel.
// Ports       : clk, rst_n (async, active-low), en, density[7:0],
//               width[PW_W-1:0], gap[PW_W-1:0], reseed, seed[LFSR_W-1:0],
//               cnt_sel[2:0] -> pulse[N_CH-1:0], busy[N_CH-1:0], count[15:0]
// Config      : PULSE_COUNT_EN - enables the per-channel counters
// Revision    : 1.0 - initial release
// ============================================================================
module random_pulse_gen_mc
    import rpg_pkg::*;
#(
    parameter int                N_CH   = 4,     // 1..8
    parameter int                LFSR_W = 16,    // 8..64
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(C_DEF_TAPS),
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(C_DEF_SEED),
    parameter int                PW_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [7:0]        density,
    input  logic [PW_W-1:0]   width,
    input  logic [PW_W-1:0]   gap,
    input  logic              reseed,
    input  logic [LFSR_W-1:0] seed,
    input  logic [2:0]        cnt_sel,
    output logic [N_CH-1:0]   pulse,
    output logic [N_CH-1:0]   busy,
    output logic [15:0]       count
);

    logic [LFSR_W-1:0]      r_lfsr;
    logic [63:0]            w_lfsr_ext;
    logic [N_CH-1:0][15:0]  w_cnt;

    // Reseed wins over stepping; a zero seed would lock the LFSR, so it
    // falls back to SEED.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED;
        end else if (reseed) begin
            r_lfsr <= (seed != '0) ? seed : SEED;
        end else if (en) begin
            r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);
        end
    end

    assign w_lfsr_ext = 64'(r_lfsr);

    // Channels see the current (pre-update) LFSR, so a trigger coinciding
    // with a reseed uses the old value.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [7:0] w_rnd;
        assign w_rnd = chan_byte(w_lfsr_ext, LFSR_W, i);

        rpg_channel #(
            .PW_W (PW_W)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en),
            .rnd     (w_rnd),
            .density (density),
            .width   (width),
            .gap     (gap),
            .pulse   (pulse[i]),
            .busy    (busy[i]),
            .count   (w_cnt[i])
        );
    end

    // Out-of-range selects read zero.
    always_comb begin
        count = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (cnt_sel == 3'(i)) begin
                count = w_cnt[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_random_pulse_gen_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_random_pulse_gen_mc
// Description : Self-checking bench for random_pulse_gen_mc. A reference model
//               tracks each channel as a trigger time plus latched width/gap
//               and derives pulse/busy windows arithmetically; directed phases
//               are followed by a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_random_pulse_gen_mc;

    localparam int          N_CH   = 4;
    localparam int          LFSR_W = 16;
    localparam int          PW_W   = 4;
    localparam logic [15:0] M_TAPS = 16'hB400;
    localparam logic [15:0] M_SEED = 16'hACE1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic [7:0]        density;
    logic [PW_W-1:0]   width;
    logic [PW_W-1:0]   gap;
    logic              reseed;
    logic [LFSR_W-1:0] seed;
    logic [2:0]        cnt_sel;
    logic [N_CH-1:0]   pulse;
    logic [N_CH-1:0]   busy;
    logic [15:0]       count;

    always #5 clk = ~clk;

    random_pulse_gen_mc #(
        .N_CH   (N_CH),
        .LFSR_W (LFSR_W),
        .PW_W   (PW_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .density (density),
        .width   (width),
        .gap     (gap),
        .reseed  (reseed),
        .seed    (seed),
        .cnt_sel (cnt_sel),
        .pulse   (pulse),
        .busy    (busy),
        .count   (count)
    );

    int     n_checks = 0;
    int     n_fail   = 0;
    longint cyc      = 0;

    // reference model state
    logic [15:0] m_lfsr;
    bit          m_act [N_CH];
    longint      m_t0  [N_CH];
    int          m_w   [N_CH];
    int          m_g   [N_CH];
    int          m_cnt [N_CH];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [7:0] m_rnd(input logic [15:0] l, input int i);
        int          s;
        logic [31:0] x;
        s = (3 * i) % 16;
        x = ({16'h0, l} << s) | ({16'h0, l} >> (16 - s));
        return x[7:0];
    endfunction

    function automatic bit m_idle(input int i, input longint c);
        return !m_act[i] || (c > m_t0[i] + m_w[i] + m_g[i]);
    endfunction

    task automatic model_reset();
        m_lfsr = M_SEED;
        for (int i = 0; i < N_CH; i++) begin
            m_act[i] = 0;
            m_t0[i]  = 0;
            m_w[i]   = 0;
            m_g[i]   = 0;
            m_cnt[i] = 0;
        end
    endtask

    // Decisions taken in cycle cyc using the inputs currently applied.
    task automatic model_cycle();
        for (int i = 0; i < N_CH; i++) begin
            if (en && m_idle(i, cyc) &&
                (density == 8'hFF || m_rnd(m_lfsr, i) < density)) begin
                m_act[i] = 1;
                m_t0[i]  = cyc;
                m_w[i]   = (width == 0) ? 1 : int'(width);
                m_g[i]   = int'(gap);
                if (m_cnt[i] < 65535) m_cnt[i]++;
            end
        end
        if (reseed)  m_lfsr = (seed != 0) ? seed : M_SEED;
        else if (en) m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? M_TAPS : 16'h0);
    endtask

    task automatic check_outputs();
        logic [N_CH-1:0] ep;
        logic [N_CH-1:0] eb;
        logic [15:0]     ec;
        for (int i = 0; i < N_CH; i++) begin
            ep[i] = m_act[i] && (cyc > m_t0[i]) && (cyc <= m_t0[i] + m_w[i]);
            eb[i] = m_act[i] && (cyc > m_t0[i]) && (cyc <= m_t0[i] + m_w[i] + m_g[i]);
        end
        ec = 16'h0;
`ifdef PULSE_COUNT_EN
        if (int'(cnt_sel) < N_CH) ec = 16'(m_cnt[cnt_sel]);
`endif
        check_eq("pulse", 32'(pulse), 32'(ep));
        check_eq("busy",  32'(busy),  32'(eb));
        check_eq("count", 32'(count), 32'(ec));
        check_eq("lfsr",  32'(dut.r_lfsr), 32'(m_lfsr));
    endtask

    task automatic step();
        model_cycle();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    // Asserts reset asynchronously mid-cycle, checks outputs drop at once.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_eq("rst_pulse", 32'(pulse), 32'h0);
        check_eq("rst_busy",  32'(busy),  32'h0);
        check_eq("rst_count", 32'(count), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        cyc++;
        check_eq("rst_lfsr", 32'(dut.r_lfsr), 32'(M_SEED));
        check_eq("rst_pulse_hold", 32'(pulse), 32'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        int          hi;
        logic [15:0] frozen;
        int          r;

        rst_n   = 1'b0;
        en      = 1'b0;
        density = 8'h00;
        width   = '0;
        gap     = '0;
        reseed  = 1'b0;
        seed    = '0;
        cnt_sel = 3'd0;
        model_reset();
        #3;
        do_reset();

        // first LFSR step from the default seed
        en = 1'b1;
        step();
        check_eq("lfsr_first", 32'(dut.r_lfsr), 32'h0000E270);

        // density 0 never triggers
        for (int j = 0; j < 1000; j++) begin
            cnt_sel = 3'(j % 8);
            step();
        end

        // width 3, gap 2: period 6, first high right after the trigger cycle
        density = 8'hFF; width = 4'd3; gap = 4'd2; cnt_sel = 3'd1;
        for (int j = 1; j <= 36; j++) begin
            step();
            check_eq("w3g2_pattern", 32'(pulse), (((j - 1) % 6) < 3) ? 32'hF : 32'h0);
        end
        density = 8'h00;
        for (int j = 0; j < 10; j++) step();

        // width 0, gap 0: alternate high/low
        density = 8'hFF; width = 4'd0; gap = 4'd0;
        for (int j = 1; j <= 20; j++) begin
            step();
            check_eq("w0g0_pattern", 32'(pulse), (j % 2 == 1) ? 32'hF : 32'h0);
        end
        density = 8'h00;
        for (int j = 0; j < 5; j++) step();

        // width 8 pulse, en dropped after two pulse cycles
        density = 8'hFF; width = 4'd8; gap = 4'd0;
        hi = 0;
        step(); hi += int'(pulse[0]);
        step(); hi += int'(pulse[0]);
        en = 1'b0;
        width = 4'd2;   // mid-pulse change must not shorten the pulse
        frozen = m_lfsr;
        for (int j = 0; j < 20; j++) begin
            step();
            hi += int'(pulse[0]);
        end
        check_eq("en_drop_width", 32'(hi), 32'd8);
        check_eq("en_drop_idle", 32'(pulse), 32'h0);
        check_eq("lfsr_frozen", 32'(dut.r_lfsr), 32'(frozen));

        // reseed with a nonzero value, then with zero
        density = 8'h00;
        reseed = 1'b1; seed = 16'h1234;
        step();
        check_eq("reseed_val", 32'(dut.r_lfsr), 32'h1234);
        seed = 16'h0000;
        step();
        check_eq("reseed_zero", 32'(dut.r_lfsr), 32'(M_SEED));
        reseed = 1'b0;

        // randomized phase
        for (int j = 0; j < 3000; j++) begin
            en = ($urandom_range(0, 9) != 0);
            r  = int'($urandom_range(0, 3));
            density = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom);
            width   = 4'($urandom_range(0, 15));
            gap     = 4'($urandom_range(0, 15));
            reseed  = ($urandom_range(0, 19) == 0);
            seed    = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            cnt_sel = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
